// File: rtl/uart_tx_fifo_scheduler_pkg.sv
// rtl/uart_tx_fifo_scheduler_pkg.sv - shared types for the UART TX FIFO scheduler
package uart_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    DRAIN_IDLE  = 3'd0,
    DRAIN_POP   = 3'd1,
    DRAIN_START = 3'd2,
    DRAIN_WAIT  = 3'd3,
    DRAIN_GAP   = 3'd4
  } drain_state_e;

endpackage

// File: rtl/uart_tx_fifo_scheduler_if.sv
// rtl/uart_tx_fifo_scheduler_if.sv - producer, FIFO and transmitter signal bundle
interface uart_tx_fifo_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  import uart_pkg::*;

  logic                   req0_valid;
  logic [DATA_WIDTH-1:0]  req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [DATA_WIDTH-1:0]  req1_data;
  logic                   req1_ready;
  logic                   fifo_wr_enable;
  logic [DATA_WIDTH-1:0]  fifo_wr_data;
  logic                   fifo_full;
  logic                   fifo_rd_enable;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_empty;
  logic                   tx_enable;
  logic                   tx_start;
  logic [DATA_WIDTH-1:0]  tx_data;
  logic                   tx_busy;
  logic                   tx_done;
  logic                   sched_busy;
  logic [FRAME_CNT_W-1:0] frames_sent;

  // The scheduler side.
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_full, fifo_rd_data, fifo_empty,
    input  tx_enable, tx_busy, tx_done,
    output req0_ready, req1_ready, fifo_wr_enable, fifo_wr_data, fifo_rd_enable,
    output tx_start, tx_data, sched_busy, frames_sent
  );

  // Producers, FIFO and transmitter side.
  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_full, fifo_rd_data, fifo_empty,
    output tx_enable, tx_busy, tx_done,
    input  req0_ready, req1_ready, fifo_wr_enable, fifo_wr_data, fifo_rd_enable,
    input  tx_start, tx_data, sched_busy, frames_sent
  );

endinterface

// File: rtl/uart_tx_fifo_scheduler_rr_arbiter2.sv
// rtl/uart_tx_fifo_scheduler_rr_arbiter2.sv - two-requester round-robin write grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       full_i,
  output logic       grant_o,
  output logic [1:0] ready_o,
  output logic       accept_o
);

  logic rr_q, rr_d;

  // A lone requester wins outright; a tie or no request falls back to the pointer.
  always_comb begin
    grant_o = rr_q;
    if (valid_i[0] && !valid_i[1]) begin
      grant_o = 1'b0;
    end else if (valid_i[1] && !valid_i[0]) begin
      grant_o = 1'b1;
    end
  end

  assign ready_o[0] = !full_i && !grant_o;
  assign ready_o[1] = !full_i && grant_o;
  assign accept_o   = valid_i[grant_o] && !full_i;
  assign rr_d       = accept_o ? !grant_o : rr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_scheduler.sv
// rtl/uart_tx_fifo_scheduler.sv - arbitrates producers into the TX FIFO and drains it into the UART
module uart_tx_fifo_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic                       clk,
  input logic                       reset,
  uart_tx_fifo_scheduler_if.master  bus
);

  localparam logic [2:0] ST_IDLE  = DRAIN_IDLE;
  localparam logic [2:0] ST_POP   = DRAIN_POP;
  localparam logic [2:0] ST_START = DRAIN_START;
  localparam logic [2:0] ST_WAIT  = DRAIN_WAIT;
  localparam logic [2:0] ST_GAP   = DRAIN_GAP;

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  logic       grant;
  logic [1:0] arb_ready;
  logic       arb_accept;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid_i  ({bus.req1_valid, bus.req0_valid}),
    .full_i   (bus.fifo_full),
    .grant_o  (grant),
    .ready_o  (arb_ready),
    .accept_o (arb_accept)
  );

  assign bus.req0_ready     = arb_ready[0];
  assign bus.req1_ready     = arb_ready[1];
  assign bus.fifo_wr_enable = arb_accept;
  assign bus.fifo_wr_data   = grant ? bus.req1_data : bus.req0_data;

  logic [2:0]             state_q, state_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    frames_d  = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_enable && !bus.fifo_empty && !bus.tx_busy) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        tx_data_d = bus.fifo_rd_data;
        state_d   = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_enable is deliberately not consulted here: a launched frame always completes.
        if (bus.tx_done) begin
          frames_d = frames_q + FRAME_CNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      tx_data_q <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      frames_q  <= frames_d;
    end
  end

  assign bus.fifo_rd_enable = (state_q == ST_POP);
  assign bus.tx_start       = (state_q == ST_START);
  assign bus.tx_data        = tx_data_q;
  assign bus.sched_busy     = (state_q != ST_IDLE);
  assign bus.frames_sent    = frames_q;

endmodule

// File: tb/tb_uart_tx_fifo_scheduler.sv
// tb/tb_uart_tx_fifo_scheduler.sv - directed bench for the scheduler with an 8-deep FIFO model
module tb_uart_tx_fifo_scheduler;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  uart_tx_fifo_scheduler_if #(.DATA_WIDTH(8)) ba ();
  uart_tx_fifo_scheduler_if #(.DATA_WIDTH(8)) bb ();

  uart_tx_fifo_scheduler #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .GAP_CYCLES(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ba)
  );

  uart_tx_fifo_scheduler #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .GAP_CYCLES(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model A: write rejected while full, head byte combinational.
  logic [7:0] mem_a [8];
  logic [2:0] wp_a, rp_a;
  logic [3:0] cnt_a;
  logic       wr_a, rd_a;
  assign ba.fifo_full    = (cnt_a == 4'd8);
  assign ba.fifo_empty   = (cnt_a == 4'd0);
  assign ba.fifo_rd_data = mem_a[rp_a];
  assign wr_a = ba.fifo_wr_enable && !ba.fifo_full;
  assign rd_a = ba.fifo_rd_enable && !ba.fifo_empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_a <= '0; rp_a <= '0; cnt_a <= '0;
    end else begin
      if (wr_a) begin
        mem_a[wp_a] <= ba.fifo_wr_data;
        wp_a <= wp_a + 3'd1;
      end
      if (rd_a) rp_a <= rp_a + 3'd1;
      cnt_a <= cnt_a + 4'(wr_a) - 4'(rd_a);
    end
  end

  logic [7:0] mem_b [8];
  logic [2:0] wp_b, rp_b;
  logic [3:0] cnt_b;
  logic       wr_b, rd_b;
  assign bb.fifo_full    = (cnt_b == 4'd8);
  assign bb.fifo_empty   = (cnt_b == 4'd0);
  assign bb.fifo_rd_data = mem_b[rp_b];
  assign wr_b = bb.fifo_wr_enable && !bb.fifo_full;
  assign rd_b = bb.fifo_rd_enable && !bb.fifo_empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_b <= '0; rp_b <= '0; cnt_b <= '0;
    end else begin
      if (wr_b) begin
        mem_b[wp_b] <= bb.fifo_wr_data;
        wp_b <= wp_b + 3'd1;
      end
      if (rd_b) rp_b <= rp_b + 3'd1;
      cnt_b <= cnt_b + 4'(wr_b) - 4'(rd_b);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    ba.req0_valid = 0; ba.req0_data = 0; ba.req1_valid = 0; ba.req1_data = 0;
    ba.tx_enable = 0; ba.tx_busy = 0; ba.tx_done = 0;
    bb.req0_valid = 0; bb.req0_data = 0; bb.req1_valid = 0; bb.req1_data = 0;
    bb.tx_enable = 0; bb.tx_busy = 0; bb.tx_done = 0;
    #2;
    chk("rst_ready0", 16'(ba.req0_ready), 16'd1);
    chk("rst_ready1", 16'(ba.req1_ready), 16'd0);
    chk("rst_wr_en", 16'(ba.fifo_wr_enable), 16'd0);
    chk("rst_rd_en", 16'(ba.fifo_rd_enable), 16'd0);
    chk("rst_tx_start", 16'(ba.tx_start), 16'd0);
    chk("rst_tx_data", 16'(ba.tx_data), 16'h0);
    chk("rst_busy", 16'(ba.sched_busy), 16'd0);
    chk("rst_frames", ba.frames_sent, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin: both producers stream until the FIFO fills.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ba.req0_valid = 1; ba.req1_valid = 1;
      ba.req0_data = 8'h10 + 8'((i + 1) / 2);
      ba.req1_data = 8'h20 + 8'(i / 2);
      #1;
      chk("rr_ready0", 16'(ba.req0_ready), 16'((i % 2) == 0));
      chk("rr_ready1", 16'(ba.req1_ready), 16'((i % 2) == 1));
      chk("rr_wr_data", 16'(ba.fifo_wr_data), (i % 2 == 0) ? 16'(8'h10 + 8'(i / 2)) : 16'(8'h20 + 8'(i / 2)));
    end
    @(negedge clk);
    ba.req1_valid = 0; ba.req0_data = 8'h99; ba.tx_enable = 1;
    #1;
    chk("full_ready0", 16'(ba.req0_ready), 16'd0);
    chk("full_ready1", 16'(ba.req1_ready), 16'd0);
    chk("full_wr_en", 16'(ba.fifo_wr_enable), 16'd0);
    for (int j = 0; j < 8; j++)
      chk("rr_fifo_order", 16'(mem_a[j]), (j % 2 == 0) ? 16'(8'h10 + 8'(j / 2)) : 16'(8'h20 + 8'(j / 2)));

    // Full boundary: pop cycle must not admit a write, next cycle does.
    @(negedge clk); #1;
    chk("fb_rd_en", 16'(ba.fifo_rd_enable), 16'd1);
    chk("fb_pop_wr_en", 16'(ba.fifo_wr_enable), 16'd0);
    @(negedge clk); #1;
    chk("fb_tx_start", 16'(ba.tx_start), 16'd1);
    chk("fb_tx_data", 16'(ba.tx_data), 16'h10);
    chk("fb_next_wr_en", 16'(ba.fifo_wr_enable), 16'd1);
    chk("fb_next_wr_data", 16'(ba.fifo_wr_data), 16'h99);

    // tx_enable dropped in WAIT: frame still completes, then no new pop.
    @(negedge clk);
    ba.req0_valid = 0; ba.tx_enable = 0;
    #1;
    chk("stall_busy", 16'(ba.sched_busy), 16'd1);
    chk("stall_tx_data", 16'(ba.tx_data), 16'h10);
    @(negedge clk);
    @(negedge clk);
    ba.tx_done = 1;
    @(negedge clk);
    ba.tx_done = 0;
    #1;
    chk("stall_frames", ba.frames_sent, 16'd1);
    chk("stall_idle", 16'(ba.sched_busy), 16'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("stall_no_pop", 16'(ba.fifo_rd_enable), 16'd0);
    end
    @(negedge clk);
    ba.tx_done = 1;
    @(negedge clk);
    ba.tx_done = 0;
    #1;
    chk("stray_frames", ba.frames_sent, 16'd1);
    chk("stray_idle", 16'(ba.sched_busy), 16'd0);

    @(negedge clk);
    ba.tx_enable = 1;
    @(negedge clk); #1;
    chk("reen_rd_en", 16'(ba.fifo_rd_enable), 16'd1);
    @(negedge clk); #1;
    chk("reen_tx_start", 16'(ba.tx_start), 16'd1);
    chk("reen_tx_data", 16'(ba.tx_data), 16'h20);

    // Reset while in WAIT takes effect before the next clock edge.
    @(negedge clk);
    ba.tx_enable = 0;
    reset = 1'b1;
    #1;
    chk("mrst_busy", 16'(ba.sched_busy), 16'd0);
    chk("mrst_tx_data", 16'(ba.tx_data), 16'h0);
    chk("mrst_frames", ba.frames_sent, 16'd0);
    chk("mrst_tx_start", 16'(ba.tx_start), 16'd0);
    chk("mrst_rd_en", 16'(ba.fifo_rd_enable), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    ba.tx_enable = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("mrst_no_start", 16'(ba.tx_start), 16'd0);
      chk("mrst_no_pop", 16'(ba.fifo_rd_enable), 16'd0);
    end

    // Single byte through producer 0 with exact drain timing.
    @(negedge clk);
    ba.req0_valid = 1; ba.req0_data = 8'h55;
    #1;
    chk("sb_ready0", 16'(ba.req0_ready), 16'd1);
    chk("sb_wr_en", 16'(ba.fifo_wr_enable), 16'd1);
    @(negedge clk);
    ba.req0_valid = 0;
    #1;
    chk("sb_seen_no_pop", 16'(ba.fifo_rd_enable), 16'd0);
    @(negedge clk); #1;
    chk("sb_pop", 16'(ba.fifo_rd_enable), 16'd1);
    @(negedge clk); #1;
    chk("sb_tx_start", 16'(ba.tx_start), 16'd1);
    chk("sb_tx_data", 16'(ba.tx_data), 16'h55);
    for (int k = 1; k < 10; k++) @(negedge clk);
    #1;
    chk("sb_wait_hold", 16'(ba.tx_data), 16'h55);
    @(negedge clk);
    ba.tx_done = 1;
    @(negedge clk);
    ba.tx_done = 0;
    #1;
    chk("sb_frames", ba.frames_sent, 16'd1);
    chk("sb_idle", 16'(ba.sched_busy), 16'd0);
    @(negedge clk); #1;
    chk("sb_empty_no_pop", 16'(ba.fifo_rd_enable), 16'd0);

    // Inter-frame gap of 3 on the second instance.
    @(negedge clk);
    bb.req1_valid = 1; bb.req1_data = 8'hA1;
    #1;
    chk("gap_ready1_a", 16'(bb.req1_ready), 16'd1);
    @(negedge clk);
    bb.req1_data = 8'hA2;
    #1;
    chk("gap_ready1_b", 16'(bb.req1_ready), 16'd1);
    @(negedge clk);
    bb.req1_valid = 0; bb.tx_enable = 1;
    @(negedge clk); #1;
    chk("gap_pop1", 16'(bb.fifo_rd_enable), 16'd1);
    @(negedge clk); #1;
    chk("gap_start1", 16'(bb.tx_start), 16'd1);
    chk("gap_data1", 16'(bb.tx_data), 16'hA1);
    @(negedge clk);
    bb.tx_done = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bb.tx_done = 0;
      #1;
      chk("gap_pop2_timing", 16'(bb.fifo_rd_enable), 16'(k == 5));
    end
    @(negedge clk); #1;
    chk("gap_start2", 16'(bb.tx_start), 16'd1);
    chk("gap_data2", 16'(bb.tx_data), 16'hA2);
    chk("gap_frames", bb.frames_sent, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_scheduler.md
# uart_tx_fifo_scheduler

Shares the UART transmit FIFO between two byte producers and drains it into the UART transmitter. A round-robin write arbiter admits one producer byte per cycle into the FIFO. A drain state machine pops one byte at a time, launches a frame on the transmitter, waits for completion, then inserts an optional inter-frame gap. Sits between the host-side producers, the `FIFO` instance (combinational read data at `rd_pointer`), and the UART TX shift engine.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the FIFO `FIFO_WIDTH`.
- `FIFO_DEPTH`, 8, FIFO depth; sizes the count port.
- `GAP_CYCLES`, 0, idle clocks inserted after each completed frame (0 = none).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req0_valid` in 1: producer 0 has a byte.
- `req0_data` in DATA_WIDTH: producer 0 byte.
- `req0_ready` out 1: producer 0 byte accepted this cycle when high together with `req0_valid`.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for producer 1.
- `fifo_wr_enable` out 1: FIFO write strobe.
- `fifo_wr_data` out DATA_WIDTH: FIFO write data.
- `fifo_full` in 1: FIFO full flag.
- `fifo_rd_enable` out 1: FIFO pop strobe.
- `fifo_rd_data` in DATA_WIDTH: FIFO head byte, combinational.
- `fifo_empty` in 1: FIFO empty flag.
- `tx_enable` in 1: drain permitted.
- `tx_start` out 1: one-cycle frame launch pulse.
- `tx_data` out DATA_WIDTH: byte for the frame; held stable from START through WAIT.
- `tx_busy` in 1: transmitter shifting.
- `tx_done` in 1: one-cycle frame-complete pulse.
- `sched_busy` out 1: drain FSM not in IDLE.
- `frames_sent` out 16: count of completed frames; wraps.

## Operation
- **Write arbiter** (combinational grant, registered pointer `rr`):
  - Exactly one of `req0_ready`/`req1_ready` is high when `fifo_full`=0; both are low when full.
  - Single valid requester: it gets the grant.
  - Both valid: the requester selected by `rr` wins.
  - Neither valid: grant goes to `rr`.
  - `fifo_wr_enable` = granted valid & ~`fifo_full`; `fifo_wr_data` = granted data.
  - On each accepted write, `rr` moves to the other requester. Reset value `rr` = 0.
  - Full plus a same-cycle pop: no write. The FIFO rejects writes while full; the scheduler does not bypass this.
- **Drain FSM** states IDLE, POP, START, WAIT, GAP; Moore outputs.
  - IDLE: go to POP when `tx_enable` & ~`fifo_empty` & ~`tx_busy`.
  - POP: `fifo_rd_enable`=1; capture `fifo_rd_data` into the `tx_data` register; go to START.
  - START: `tx_start`=1; go to WAIT.
  - WAIT: on `tx_done`, increment `frames_sent`. Go to GAP (load gap counter with `GAP_CYCLES`−1) if `GAP_CYCLES`>0, else go to IDLE.
  - GAP: decrement the counter; go to IDLE when it reaches 0.
  - `tx_done` outside WAIT is ignored.
  - Deasserting `tx_enable` mid-frame does not abort the frame. It blocks only the next IDLE→POP transition.
- **Reset values**:
  - FSM=IDLE; `rr`=0; gap counter=0.
  - `fifo_rd_enable`=0, `tx_start`=0, `tx_data`=0, `sched_busy`=0, `frames_sent`=0.
  - Ready and write outputs follow their combinational equations.
- **Reset mid-frame**: return to IDLE immediately. A popped but unsent byte is dropped and not re-queued.

## Timing
- From IDLE with the start condition true at edge N: `fifo_rd_enable` high in cycle N+1, `tx_start` high in cycle N+2.
- Back-to-back frames, `GAP_CYCLES`=0: the next `fifo_rd_enable` comes 2 cycles after the `tx_done` cycle (WAIT→IDLE→POP).
- With gap G: 2+G cycles after the `tx_done` cycle.
- Write path has zero latency: ready and write strobe are in the same cycle as valid.
- `frames_sent` updates at the edge following the `tx_done` cycle; 0xFFFF+1 wraps to 0.

## Structure
- Shared package `uart_pkg`: drain state enum (IDLE, POP, START, WAIT, GAP), `FRAME_CNT_W`=16.
- One sub-module, `rr_arbiter2`, holds the two-requester round-robin grant and `rr` pointer. The drain FSM lives in the top.
- Integration test instantiates `FIFO` alongside the scheduler.

## Test plan
- **Single byte:** write 0x55 via producer 0, `tx_enable`=1, bench `tx_done` 10 cycles after `tx_start`. Required: pop 1 cycle after non-empty is seen, `tx_start` the next cycle with `tx_data`=0x55, `frames_sent`=1, return to IDLE.
- **Round robin:** both producers stream for 8 cycles, p0 0x10.., p1 0x20... Required: FIFO contents alternate 0x10,0x20,0x11,0x21…; both readys low once full (8 entries).
- **Gap:** `GAP_CYCLES`=3, two queued bytes. Required: second `fifo_rd_enable` exactly 5 cycles after the first `tx_done` cycle.
- **Stalls and stray pulses:** `tx_enable` dropped during WAIT. Required: frame completes, no further pop until re-enabled. Stray `tx_done` in IDLE: `frames_sent` unchanged.
- **Reset mid-frame:** `reset` in WAIT. Required: all outputs at reset values asynchronously; after release, no `tx_start` without a new FIFO write.
- **Full boundary:** FIFO full, producer valid and FSM popping in the same cycle. Required: no write that cycle; write accepted the next cycle.
